// File: rtl/alu_seq_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alu_seq_pkg
// Brief    : Shared op codes, state encoding and default width for the ALU
//            sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
package alu_seq_pkg;

   localparam int DEFAULT_WIDTH = 16;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_XOR   = 2'b10;
   localparam logic [1:0] OP_LOADB = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD_A = 2'd1,
      S_EXEC   = 2'd2,
      S_RESULT = 2'd3
   } state_t;

   // Source of the value written into the ALU A register.
   typedef enum logic [1:0] {
      ASEL_OPA  = 2'd0,
      ASEL_ACC  = 2'd1,
      ASEL_ZERO = 2'd2
   } asel_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_decode.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alu_seq_decode
// Brief    : Maps the latched op/chain to the A-source select and ALU controls.
// Revision : 1.0
//------------------------------------------------------------------------------
module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  logic [1:0] i_op,
   input  logic       i_chain,
   output asel_t      o_a_sel,
   output logic       o_addsub,
   output logic       o_xor_ctrl
);

   always_comb begin
      o_a_sel    = ASEL_OPA;
      o_addsub   = 1'b0;
      o_xor_ctrl = 1'b0;
      case (i_op)
         OP_SUB:  o_addsub   = 1'b1;
         OP_XOR:  o_xor_ctrl = 1'b1;
         default: ;
      endcase
      // LOADB clears A regardless of chain so the accumulate yields plain B.
      if (i_op == OP_LOADB) begin
         o_a_sel = ASEL_ZERO;
      end else if (i_chain) begin
         o_a_sel = ASEL_ACC;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alu_sequencer
// Brief    : Valid/ready command sequencer driving the accumulator ALU through
//            LOAD_A, EXEC and RESULT phases. Optional ALU_SEQ_FLAGS_EN adds
//            res_zero/res_neg result flags.
// Revision : 1.0
//------------------------------------------------------------------------------
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic             cmd_chain,
   input  logic [WIDTH-1:0] cmd_opa,
   input  logic [WIDTH-1:0] cmd_opb,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_a_enable,
   output logic             alu_addsub,
   output logic             alu_xor_ctrl,
   output logic             alu_acc_enable,
   input  logic [WIDTH-1:0] alu_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             busy
`ifdef ALU_SEQ_FLAGS_EN
   ,
   output logic             res_zero,
   output logic             res_neg
`endif
);

   state_t           r_state;
   logic [1:0]       r_op;
   logic             r_chain;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;

   asel_t            w_a_sel;
   logic             w_addsub;
   logic             w_xor_ctrl;
   logic [WIDTH-1:0] w_a_src;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op    <= OP_ADD;
         r_chain <= 1'b0;
         r_opa   <= '0;
         r_opb   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_op    <= cmd_op;
                  r_chain <= cmd_chain;
                  r_opa   <= cmd_opa;
                  r_opb   <= cmd_opb;
                  r_state <= S_LOAD_A;
               end
            end
            S_LOAD_A: r_state <= S_EXEC;
            S_EXEC:   r_state <= S_RESULT;
            S_RESULT: begin
               if (res_ready) begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   alu_seq_decode u_decode (
      .i_op       (r_op),
      .i_chain    (r_chain),
      .o_a_sel    (w_a_sel),
      .o_addsub   (w_addsub),
      .o_xor_ctrl (w_xor_ctrl)
   );

   // The accumulator only changes on the EXEC edge, so alu_out is stable here.
   always_comb begin
      case (w_a_sel)
         ASEL_ACC:  w_a_src = alu_out;
         ASEL_ZERO: w_a_src = '0;
         default:   w_a_src = r_opa;
      endcase
   end

   assign cmd_ready      = (r_state == S_IDLE);
   assign busy           = (r_state != S_IDLE);
   assign alu_a_enable   = (r_state == S_LOAD_A);
   assign alu_acc_enable = (r_state == S_EXEC);
   assign res_valid      = (r_state == S_RESULT);

   assign alu_a        = alu_a_enable   ? w_a_src : '0;
   assign alu_b        = alu_acc_enable ? r_opb   : '0;
   assign alu_addsub   = alu_acc_enable & w_addsub;
   assign alu_xor_ctrl = alu_acc_enable & w_xor_ctrl;
   assign res_data     = res_valid ? alu_out : '0;

`ifdef ALU_SEQ_FLAGS_EN
   assign res_zero = res_valid & (alu_out == '0);
   assign res_neg  = res_valid & alu_out[WIDTH-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_alu_sequencer
// Brief    : Self-checking bench for alu_sequencer with a behavioural ALU model
//            and a result scoreboard.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [1:0]   cmd_op = 2'b00;
   logic         cmd_chain = 1'b0;
   logic [W-1:0] cmd_opa = '0;
   logic [W-1:0] cmd_opb = '0;
   logic [W-1:0] alu_a, alu_b, alu_out, res_data;
   logic         alu_a_enable, alu_addsub, alu_xor_ctrl, alu_acc_enable;
   logic         res_valid, busy;
   logic         res_ready = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
   logic         res_zero, res_neg;
`endif

   always #5 clk = ~clk;

   alu_sequencer #(.WIDTH(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_op         (cmd_op),
      .cmd_chain      (cmd_chain),
      .cmd_opa        (cmd_opa),
      .cmd_opb        (cmd_opb),
      .alu_a          (alu_a),
      .alu_b          (alu_b),
      .alu_a_enable   (alu_a_enable),
      .alu_addsub     (alu_addsub),
      .alu_xor_ctrl   (alu_xor_ctrl),
      .alu_acc_enable (alu_acc_enable),
      .alu_out        (alu_out),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_data       (res_data),
      .busy           (busy)
`ifdef ALU_SEQ_FLAGS_EN
      ,
      .res_zero       (res_zero),
      .res_neg        (res_neg)
`endif
   );

   // Behavioural accumulator ALU sharing the sequencer's reset.
   logic [W-1:0] m_areg, m_acc;
   always @(posedge clk) begin
      if (rst) begin
         m_areg <= '0;
         m_acc  <= '0;
      end else begin
         if (alu_a_enable) m_areg <= alu_a;
         if (alu_acc_enable)
            m_acc <= alu_xor_ctrl ? (m_areg ^ alu_b) :
                     alu_addsub   ? (m_areg - alu_b) : (m_areg + alu_b);
      end
   end
   assign alu_out = m_acc;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] sb_q[$];
   logic [W-1:0] last_res = '0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one command from IDLE and walks it through every phase; with
   // hold>0 the result is back-pressured while an intruder command waits.
   task automatic run_op(input string name, input logic [1:0] op, input logic chain,
                         input logic [W-1:0] opa, input logic [W-1:0] opb,
                         input logic [W-1:0] exp, input int hold);
      logic [W-1:0] exp_a;
      logic [W-1:0] want;
      exp_a = (op == OP_LOADB) ? '0 : (chain ? last_res : opa);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL %s idle_ready got %b want 1", name, cmd_ready);
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_chain = chain; cmd_opa = opa; cmd_opb = opb;
      sb_q.push_back(exp);
      step();
      cmd_valid = 1'b0; cmd_op = W'($urandom) & 2'b11; cmd_chain = ~chain;
      cmd_opa = W'($urandom); cmd_opb = W'($urandom);
      checks++;
      if ({alu_a_enable, alu_acc_enable, busy, cmd_ready, res_valid} !== 5'b10100) begin
         errors++; $display("FAIL %s load_ctl got %b want 10100", name,
                            {alu_a_enable, alu_acc_enable, busy, cmd_ready, res_valid});
      end
      checks++;
      if (alu_a !== exp_a || alu_b !== '0) begin
         errors++; $display("FAIL %s load_ops got a=%h b=%h want a=%h b=0000", name, alu_a, alu_b, exp_a);
      end
      step();
      checks++;
      if ({alu_a_enable, alu_acc_enable, alu_addsub, alu_xor_ctrl, res_valid} !==
          {1'b0, 1'b1, op == OP_SUB, op == OP_XOR, 1'b0}) begin
         errors++; $display("FAIL %s exec_ctl got %b want %b", name,
                            {alu_a_enable, alu_acc_enable, alu_addsub, alu_xor_ctrl, res_valid},
                            {1'b0, 1'b1, op == OP_SUB, op == OP_XOR, 1'b0});
      end
      checks++;
      if (alu_b !== opb || alu_a !== '0) begin
         errors++; $display("FAIL %s exec_ops got a=%h b=%h want a=0000 b=%h", name, alu_a, alu_b, opb);
      end
      step();
      want = (sb_q.size() > 0) ? sb_q.pop_front() : ~exp;
      for (int i = 0; i <= hold; i++) begin
         checks++;
         if (res_valid !== 1'b1 || res_data !== want || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL %s result[%0d] got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                               name, i, res_valid, res_data, cmd_ready, want);
         end
         checks++;
         if ({alu_a_enable, alu_acc_enable, alu_addsub, alu_xor_ctrl} !== 4'b0000) begin
            errors++; $display("FAIL %s result_ctl got %b want 0000", name,
                               {alu_a_enable, alu_acc_enable, alu_addsub, alu_xor_ctrl});
         end
`ifdef ALU_SEQ_FLAGS_EN
         checks++;
         if (res_zero !== (want == '0) || res_neg !== want[W-1]) begin
            errors++; $display("FAIL %s flags got z=%b n=%b want z=%b n=%b", name,
                               res_zero, res_neg, want == '0, want[W-1]);
         end
`endif
         if (i < hold) begin
            cmd_valid = 1'b1; cmd_op = OP_XOR; cmd_chain = 1'b0;
            cmd_opa = 16'h00F0; cmd_opb = 16'h000F;
            step();
         end
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      last_res = exp;
      checks++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || res_data !== '0) begin
         errors++; $display("FAIL %s after_handshake got v=%b rdy=%b busy=%b d=%h want 0 1 0 0000",
                            name, res_valid, cmd_ready, busy, res_data);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      checks++;
      if ({cmd_ready, busy, res_valid, alu_a_enable, alu_acc_enable, alu_addsub, alu_xor_ctrl} !== 7'b1000000 ||
          res_data !== '0 || alu_a !== '0 || alu_b !== '0) begin
         errors++; $display("FAIL reset_state got ctl=%b d=%h a=%h b=%h want 1000000 0000 0000 0000",
                            {cmd_ready, busy, res_valid, alu_a_enable, alu_acc_enable, alu_addsub, alu_xor_ctrl},
                            res_data, alu_a, alu_b);
      end
`ifdef ALU_SEQ_FLAGS_EN
      checks++;
      if (res_zero !== 1'b0 || res_neg !== 1'b0) begin
         errors++; $display("FAIL reset_flags got z=%b n=%b want 0 0", res_zero, res_neg);
      end
`endif
      rst = 1'b0;
      last_res = '0;
      step();
   endtask

   task automatic test_add();
      run_op("add", OP_ADD, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 0);
   endtask

   task automatic test_sub();
      run_op("sub", OP_SUB, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 0);
   endtask

   task automatic test_xor_chain();
      run_op("xor", OP_XOR, 1'b0, 16'hAAAA, 16'h0F0F, 16'hA5A5, 0);
      run_op("chain_add", OP_ADD, 1'b1, 16'hFFFF, 16'h0001, 16'hA5A6, 0);
   endtask

   task automatic test_loadb();
      run_op("loadb", OP_LOADB, 1'b1, 16'h1111, 16'h00FF, 16'h00FF, 0);
   endtask

   task automatic test_wrap();
      run_op("wrap_add", OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 0);
   endtask

   task automatic test_backpressure();
      run_op("backpressure", OP_ADD, 1'b0, 16'h0100, 16'h0023, 16'h0123, 5);
      run_op("after_bp", OP_XOR, 1'b0, 16'h00F0, 16'h000F, 16'h00FF, 0);
   endtask

   task automatic test_reset_mid_op();
      cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_chain = 1'b0; cmd_opa = 16'h0001; cmd_opb = 16'h0001;
      step();
      cmd_valid = 1'b0;
      step();
      checks++;
      if (alu_acc_enable !== 1'b1) begin
         errors++; $display("FAIL rst_mid reach_exec got acc_en=%b want 1", alu_acc_enable);
      end
      rst = 1'b1;
      step();
      checks++;
      if ({cmd_ready, busy, res_valid, alu_a_enable, alu_acc_enable, alu_addsub, alu_xor_ctrl} !== 7'b1000000 ||
          res_data !== '0 || alu_a !== '0 || alu_b !== '0) begin
         errors++; $display("FAIL rst_mid state got ctl=%b d=%h a=%h b=%h want 1000000 0000 0000 0000",
                            {cmd_ready, busy, res_valid, alu_a_enable, alu_acc_enable, alu_addsub, alu_xor_ctrl},
                            res_data, alu_a, alu_b);
      end
      rst = 1'b0;
      last_res = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid no_result[%0d] got v=%b busy=%b want 0 0", i, res_valid, busy);
         end
      end
      run_op("chain_after_rst", OP_ADD, 1'b1, 16'h7777, 16'h0003, 16'h0003, 0);
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_xor_chain();
      test_loadb();
      test_wrap();
      test_backpressure();
      test_reset_mid_op();
      checks++;
      if (sb_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
